// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_pkg: shared constants for the forwarding/hazard unit.
//   - ADDR_W_DEF : default register address width
//   - X0_ADDR    : hard-wired zero register, never forwarded
//   - tracker entry layout {valid, rd[aw-1:0], is_load}, with helper
//     functions giving width and field offsets for a given address width
package fwd_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int X0_ADDR    = 0;

  function automatic int ent_w(input int aw);
    return aw + 2;
  endfunction
  function automatic int ent_ld_ofs(input int aw);
    return (aw > 0) ? 0 : 0;
  endfunction
  function automatic int ent_rd_ofs(input int aw);
    return (aw > 0) ? 1 : 1;
  endfunction
  function automatic int ent_vld_ofs(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-side bundle for the forwarding/hazard unit.
//   master : ID stage (drives instruction info / pipeline control)
//   slave  : fwd_hazard_unit (returns forwarding selects and stall)
// stall_cnt_out exists only when FWD_STALL_CNT_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 3,
  parameter int ADDR_W         = fwd_pkg::ADDR_W_DEF
) ();
  logic                          id_valid_in;
  logic [NUM_SRC*ADDR_W-1:0]     id_rs_addr_in;
  logic [ADDR_W-1:0]             id_rd_addr_in;
  logic                          id_rd_wen_in;
  logic                          id_is_load_in;
  logic                          pipe_adv_in;
  logic                          flush_in;
  logic [NUM_SRC*NUM_FWD_STAGES-1:0] fwd_sel_out;
  logic                          stall_out;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]                   stall_cnt_out;
`endif

  modport master (
    output id_valid_in, id_rs_addr_in, id_rd_addr_in, id_rd_wen_in,
           id_is_load_in, pipe_adv_in, flush_in,
`ifdef FWD_STALL_CNT_EN
    input  stall_cnt_out,
`endif
    input  fwd_sel_out, stall_out
  );

  modport slave (
    input  id_valid_in, id_rs_addr_in, id_rd_addr_in, id_rd_wen_in,
           id_is_load_in, pipe_adv_in, flush_in,
`ifdef FWD_STALL_CNT_EN
    output stall_cnt_out,
`endif
    output fwd_sel_out, stall_out
  );
endinterface

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match_cell: priority matcher for one source operand.
//   rs        : source register address
//   trk_vld/rd/ld : tracker vector, index 0 = youngest stage
//   sel       : one-hot forward select (youngest matching producer)
//   stall     : youngest producer is a load whose data is not ready yet
module fwd_match_cell
  import fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES   = 3,
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic [ADDR_W-1:0]                     rs,
  input  logic [NUM_FWD_STAGES-1:0]             trk_vld,
  input  logic [NUM_FWD_STAGES-1:0][ADDR_W-1:0] trk_rd,
  input  logic [NUM_FWD_STAGES-1:0]             trk_ld,
  output logic [NUM_FWD_STAGES-1:0]             sel,
  output logic                                  stall
);
  logic hit;

  // Scan youngest to oldest; the first hit masks every older stage.
  always_comb begin
    sel   = '0;
    stall = 1'b0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      if (!hit && trk_vld[k] && trk_rd[k] == rs && rs != ADDR_W'(X0_ADDR)) begin
        hit = 1'b1;
        if (!trk_ld[k] || k >= LOAD_READY_STAGE) sel[k] = 1'b1;
        else                                      stall  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: decode-stage forwarding select and load-use stall.
//   clk_in, rst_n_in : clock, async active-low reset
//   bus (slave)      : ID instruction info, pipe_adv/flush controls in;
//                      fwd_sel_out (bit s*NUM_FWD_STAGES+k), stall_out out
// Optional: FWD_STALL_CNT_EN adds a saturating 32-bit stall_cnt_out that
// counts cycles with stall_out && pipe_adv_in.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC          = 2,
  parameter int NUM_FWD_STAGES   = 3,
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int LOAD_READY_STAGE = 1,
  parameter int FLUSH_STAGES     = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  fwd_hazard_unit_if.slave bus
);
  localparam int EW   = ent_w(ADDR_W);
  localparam int O_LD = ent_ld_ofs(ADDR_W);
  localparam int O_RD = ent_rd_ofs(ADDR_W);
  localparam int O_V  = ent_vld_ofs(ADDR_W);

  logic [NUM_FWD_STAGES-1:0][EW-1:0]     trk;
  logic [NUM_FWD_STAGES-1:0]             trk_vld;
  logic [NUM_FWD_STAGES-1:0][ADDR_W-1:0] trk_rd;
  logic [NUM_FWD_STAGES-1:0]             trk_ld;
  logic [NUM_SRC-1:0][NUM_FWD_STAGES-1:0] sel_arr;
  logic [NUM_SRC-1:0]                    stall_term;
  logic                                  stall;
  logic                                  load_ok;
  logic [EW-1:0]                         new_ent;

  for (genvar k = 0; k < NUM_FWD_STAGES; k++) begin : g_unpack
    assign trk_vld[k] = trk[k][O_V];
    assign trk_rd[k]  = trk[k][O_RD +: ADDR_W];
    assign trk_ld[k]  = trk[k][O_LD];
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match_cell #(
      .NUM_FWD_STAGES  (NUM_FWD_STAGES),
      .ADDR_W          (ADDR_W),
      .LOAD_READY_STAGE(LOAD_READY_STAGE)
    ) u_cell (
      .rs     (bus.id_rs_addr_in[s*ADDR_W +: ADDR_W]),
      .trk_vld(trk_vld),
      .trk_rd (trk_rd),
      .trk_ld (trk_ld),
      .sel    (sel_arr[s]),
      .stall  (stall_term[s])
    );
  end

  assign stall           = bus.id_valid_in && |stall_term;
  assign bus.stall_out   = stall;
  assign bus.fwd_sel_out = bus.id_valid_in ? sel_arr : '0;

  // A stalled or flushed ID instruction enters the pipe as a bubble.
  assign load_ok = bus.id_valid_in && !stall && !bus.flush_in;
  assign new_ent = {load_ok && bus.id_rd_wen_in && bus.id_rd_addr_in != ADDR_W'(X0_ADDR),
                    bus.id_rd_addr_in, bus.id_is_load_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      trk <= '0;
    end else begin
      if (bus.pipe_adv_in) begin
        for (int k = NUM_FWD_STAGES - 1; k > 0; k--) trk[k] <= trk[k-1];
        trk[0] <= new_ent;
      end
      // Later assignment wins: flush overrides shift for the young stages.
      if (bus.flush_in)
        for (int k = 0; k < FLUSH_STAGES; k++) trk[k][O_V] <= 1'b0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                                        stall_cnt <= '0;
    else if (stall && bus.pipe_adv_in && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
  assign bus.stall_cnt_out = stall_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (NUM_SRC=2, NUM_FWD_STAGES=3,
// LOAD_READY_STAGE=1, FLUSH_STAGES=1). Stimulus pushes the expected
// {fwd_sel, stall} for each driven cycle; a monitor pops and compares at
// the following falling edge.
module tb_fwd_hazard_unit;
  localparam int NS = 2, NF = 3, AW = 5;

  typedef struct {
    logic [NS*NF-1:0] sel;
    logic             stall;
    string            nm;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  fwd_hazard_unit_if #(.NUM_SRC(NS), .NUM_FWD_STAGES(NF), .ADDR_W(AW)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .ADDR_W(AW),
    .LOAD_READY_STAGE(1), .FLUSH_STAGES(1)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: outputs are combinational, so every driven cycle presents one.
  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.fwd_sel_out !== e.sel || bus.stall_out !== e.stall) begin
        errors++;
        $display("FAIL %s: got sel=%b stall=%b, want sel=%b stall=%b",
                 e.nm, bus.fwd_sel_out, bus.stall_out, e.sel, e.stall);
      end
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] rd, input logic wen, input logic ld,
                       input logic adv, input logic fl);
    bus.id_valid_in   = v;
    bus.id_rs_addr_in = {r2, r1};
    bus.id_rd_addr_in = rd;
    bus.id_rd_wen_in  = wen;
    bus.id_is_load_in = ld;
    bus.pipe_adv_in   = adv;
    bus.flush_in      = fl;
  endtask

  task automatic step(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] rd, input logic wen, input logic ld,
                      input logic adv, input logic fl,
                      input logic [NS*NF-1:0] es, input logic est, input string nm);
    @(posedge clk_in); #1;
    drive(v, r1, r2, rd, wen, ld, adv, fl);
    q.push_back('{sel: es, stall: est, nm: nm});
  endtask

  initial begin
    rst_n_in = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    q.push_back('{sel: 6'b0, stall: 1'b0, nm: "reset_initial"});
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    //    v  rs1    rs2    rd     wen  ld   adv  fl   sel        stall
    // ALU chain
    step(1, 5'd0,  5'd0,  5'd5,  1,   0,   1,   0,   6'b000000, 0, "alu_first");
    step(1, 5'd5,  5'd5,  5'd6,  1,   0,   1,   0,   6'b001001, 0, "alu_chain");
    step(0, 5'd0,  5'd0,  5'd0,  0,   0,   1,   0,   6'b000000, 0, "bubble");
    step(1, 5'd5,  5'd6,  5'd0,  0,   0,   1,   0,   6'b010100, 0, "older_stages");
    // Youngest producer wins
    step(1, 5'd0,  5'd0,  5'd7,  1,   0,   1,   0,   6'b000000, 0, "x0_no_match");
    step(1, 5'd0,  5'd0,  5'd0,  0,   0,   1,   0,   6'b000000, 0, "idle");
    step(1, 5'd0,  5'd0,  5'd7,  1,   0,   1,   0,   6'b000000, 0, "write_x7_again");
    // Hold for three cycles with pipe_adv_in=0
    step(1, 5'd7,  5'd2,  5'd0,  0,   0,   0,   0,   6'b000001, 0, "youngest_wins");
    step(1, 5'd7,  5'd2,  5'd0,  0,   0,   0,   0,   6'b000001, 0, "hold_1");
    step(1, 5'd7,  5'd2,  5'd0,  0,   0,   0,   0,   6'b000001, 0, "hold_2");
    step(1, 5'd7,  5'd7,  5'd0,  0,   0,   1,   0,   6'b001001, 0, "hold_3_both");
    // Load-use
    step(1, 5'd7,  5'd0,  5'd8,  1,   1,   1,   0,   6'b000010, 0, "lw_issue");
    step(1, 5'd8,  5'd0,  5'd9,  1,   0,   1,   0,   6'b000000, 1, "load_use_stall");
    step(1, 5'd8,  5'd0,  5'd9,  1,   0,   1,   0,   6'b000010, 0, "load_use_fwd");
    step(1, 5'd8,  5'd9,  5'd0,  0,   0,   1,   0,   6'b001100, 0, "load_stage2_alu_stage0");
    // Flush with producer in stage 0, pipe held
    step(1, 5'd0,  5'd0,  5'd10, 1,   0,   1,   0,   6'b000000, 0, "write_x10");
    step(1, 5'd10, 5'd9,  5'd0,  0,   0,   0,   1,   6'b100001, 0, "pre_flush");
    step(1, 5'd10, 5'd9,  5'd0,  0,   0,   1,   0,   6'b100000, 0, "post_flush");
    step(0, 5'd0,  5'd9,  5'd0,  0,   0,   1,   0,   6'b000000, 0, "invalid_gated");
    // Fill tracker, then reset mid-operation
    step(1, 5'd0,  5'd0,  5'd12, 1,   0,   1,   0,   6'b000000, 0, "fill_1");
    step(1, 5'd12, 5'd0,  5'd13, 1,   0,   1,   0,   6'b000001, 0, "fill_2");
    step(1, 5'd12, 5'd13, 5'd14, 1,   0,   1,   0,   6'b001010, 0, "fill_3");
    @(posedge clk_in); #1;
    drive(1'b1, 5'd14, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n_in = 1'b0;
    q.push_back('{sel: 6'b0, stall: 1'b0, nm: "reset_full_tracker"});
    @(posedge clk_in); #1 rst_n_in = 1'b1;
    q.push_back('{sel: 6'b0, stall: 1'b0, nm: "after_reset"});
    step(1, 5'd13, 5'd12, 5'd0,  0,   0,   1,   0,   6'b000000, 0, "after_reset_2");

`ifdef FWD_STALL_CNT_EN
    // Counter was cleared by the reset above: 5 counted stalls, 2 held ones.
    for (int i = 0; i < 5; i++) begin
      step(1, 5'd0,  5'd0,  5'd11, 1, 1, 1, 0, 6'b000000, 0, "cnt_lw");
      if (i == 0) begin
        step(1, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 6'b000000, 1, "cnt_stall_hold_a");
        step(1, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 6'b000000, 1, "cnt_stall_hold_b");
      end
      step(1, 5'd11, 5'd0,  5'd0,  0, 0, 1, 0, 6'b000000, 1, "cnt_stall");
      step(1, 5'd11, 5'd0,  5'd0,  0, 0, 1, 0, 6'b000010, 0, "cnt_fwd");
    end
    @(posedge clk_in); #1;
    checks++;
    if (bus.stall_cnt_out !== 32'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, want 5", bus.stall_cnt_out);
    end
`endif

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_in);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
